// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//   Top-level Pong game controller. It detects goals from the ball x
//   position, keeps both scores, holds a timed serve pause after each point
//   and declares the winner. The ball and paddle controllers are driven from
//   `state`, and the ball is held at screen centre whenever state != PLAY.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   timing_tick  in   one-cycle frame tick shared with the ball datapath
//   start_btn    in   debounced start button (level)
//   x_ball       in   [10:0] current ball x position
//   state        out  [1:0] IDLE=0, PLAY=1, SERVE=2, GAME_OVER=3
//   score_left   out  [3:0] left player score
//   score_right  out  [3:0] right player score
//   winner       out  0 = left won, 1 = right won (meaningful in GAME_OVER)
//   point_pulse  out  one-cycle pulse when a point is awarded
//
// Build option
//   GAME_WIN_BY_TWO_EN : a game ends only when the scorer has at least
//   WIN_SCORE points and leads by two or more. Scores saturate at 15, and
//   reaching 15 wins regardless of margin. Undefined: the first player to
//   reach WIN_SCORE wins.
//
// State table
//   state     | meaning
//   IDLE      | waiting for a start press; scores from the last game are kept
//   SERVE     | ball centred, counting SERVE_TICKS frame ticks down
//   PLAY      | ball live, goals evaluated on each frame tick
//   GAME_OVER | scores and winner frozen until the next start press
// ---------------------------------------------------------------------------
module game_sequencer #(
   parameter int WIN_SCORE    = 5,
   parameter int SERVE_TICKS  = 60,
   parameter int LEFT_GOAL_X  = 8,
   parameter int RIGHT_GOAL_X = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        timing_tick,
   input  logic        start_btn,
   input  logic [10:0] x_ball,
   output logic [1:0]  state,
   output logic [3:0]  score_left,
   output logic [3:0]  score_right,
   output logic        winner,
   output logic        point_pulse
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PLAY      = 2'd1,
      SERVE     = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
   localparam logic [7:0]  SERVE_LOAD = 8'(SERVE_TICKS);
   localparam logic [10:0] LEFT_X     = 11'(LEFT_GOAL_X);
   localparam logic [10:0] RIGHT_X    = 11'(RIGHT_GOAL_X);

   state_t      state_q;
   logic [7:0]  serve_cnt;
   logic        start_btn_q;
   logic        start_rise;
   logic        goal_right;
   logic        goal_left;
   logic [3:0]  right_next;
   logic [3:0]  left_next;
   logic        right_wins;
   logic        left_wins;

   assign start_rise = start_btn & ~start_btn_q;

   // The left-goal check wins if both limits match (misconfigured limits only).
   assign goal_right = (x_ball <= LEFT_X);
   assign goal_left  = !goal_right && (x_ball >= RIGHT_X);

`ifdef GAME_WIN_BY_TWO_EN
   assign right_next = (score_right == 4'd15) ? 4'd15 : score_right + 4'd1;
   assign left_next  = (score_left  == 4'd15) ? 4'd15 : score_left  + 4'd1;
   assign right_wins = (right_next == 4'd15) ||
                       ((right_next >= WIN) &&
                        ({1'b0, right_next} >= ({1'b0, score_left} + 5'd2)));
   assign left_wins  = (left_next == 4'd15) ||
                       ((left_next >= WIN) &&
                        ({1'b0, left_next} >= ({1'b0, score_right} + 5'd2)));
`else
   assign right_next = score_right + 4'd1;
   assign left_next  = score_left  + 4'd1;
   assign right_wins = (right_next == WIN);
   assign left_wins  = (left_next  == WIN);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         serve_cnt   <= 8'd0;
         start_btn_q <= 1'b0;
         score_left  <= 4'd0;
         score_right <= 4'd0;
         winner      <= 1'b0;
         point_pulse <= 1'b0;
      end else begin
         start_btn_q <= start_btn;
         point_pulse <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_rise) begin
                  score_left  <= 4'd0;
                  score_right <= 4'd0;
                  serve_cnt   <= SERVE_LOAD;
                  state_q     <= SERVE;
               end
            end
            SERVE: begin
               // The tick that takes the count to zero also releases the ball.
               if (timing_tick) begin
                  if (serve_cnt <= 8'd1) begin
                     serve_cnt <= 8'd0;
                     state_q   <= PLAY;
                  end else begin
                     serve_cnt <= serve_cnt - 8'd1;
                  end
               end
            end
            PLAY: begin
               if (timing_tick) begin
                  if (goal_right) begin
                     score_right <= right_next;
                     point_pulse <= 1'b1;
                     if (right_wins) begin
                        winner  <= 1'b1;
                        state_q <= GAME_OVER;
                     end else begin
                        serve_cnt <= SERVE_LOAD;
                        state_q   <= SERVE;
                     end
                  end else if (goal_left) begin
                     score_left  <= left_next;
                     point_pulse <= 1'b1;
                     if (left_wins) begin
                        winner  <= 1'b0;
                        state_q <= GAME_OVER;
                     end else begin
                        serve_cnt <= SERVE_LOAD;
                        state_q   <= SERVE;
                     end
                  end
               end
            end
            GAME_OVER: begin
               if (start_rise) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_SERV = 2'd2;
   localparam logic [1:0] S_OVER = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        timing_tick;
   logic        start_btn;
   logic [10:0] x_ball;
   logic [1:0]  state;
   logic [3:0]  score_left;
   logic [3:0]  score_right;
   logic        winner;
   logic        point_pulse;

   game_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .timing_tick (timing_tick),
      .start_btn   (start_btn),
      .x_ball      (x_ball),
      .state       (state),
      .score_left  (score_left),
      .score_right (score_right),
      .winner      (winner),
      .point_pulse (point_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] st;
      logic [3:0] l;
      logic [3:0] r;
      logic       w;
      logic       pp;
   } ev_t;

   ev_t   exp_q[$];
   string name_q[$];
   int    check_cnt = 0;
   int    pass_cnt  = 0;
   logic  rst_q = 1'b0;

   // Mirrors the DUT's sampling of rst so the monitor knows a reset edge occurred.
   always @(posedge clk) rst_q <= rst;

   // Monitor: an output event is a reset edge, a state change or a point pulse.
   initial begin : monitor
      logic [1:0] prev_state;
      ev_t        e;
      string      nm;
      logic       bad;
      prev_state = S_IDLE;
      forever begin
         @(negedge clk);
         if (rst_q || (state !== prev_state) || (point_pulse !== 1'b0)) begin
            check_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_event: got st=%0d l=%0d r=%0d w=%0d pp=%0d, required no event",
                        state, score_left, score_right, winner, point_pulse);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               bad = (state !== e.st) || (score_left !== e.l) || (score_right !== e.r) ||
                     (point_pulse !== e.pp) || ((e.st == S_OVER) && (winner !== e.w));
               if (bad)
                  $display("FAIL %s: got st=%0d l=%0d r=%0d w=%0d pp=%0d, required st=%0d l=%0d r=%0d w=%0d pp=%0d",
                           nm, state, score_left, score_right, winner, point_pulse,
                           e.st, e.l, e.r, e.w, e.pp);
               else
                  pass_cnt++;
            end
         end
         prev_state = state;
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [1:0] st, input logic [3:0] l, input logic [3:0] r,
                       input logic w, input logic pp, input string nm);
      ev_t e;
      e.st = st; e.l = l; e.r = r; e.w = w; e.pp = pp;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Every expected event must have been seen within a few cycles.
   task automatic drain(input string nm);
      cyc(3);
      check_cnt++;
      if (exp_q.size() != 0) begin
         $display("FAIL drain_%s: %0d expected events pending, required 0", nm, exp_q.size());
         exp_q.delete();
         name_q.delete();
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic do_tick();
      timing_tick = 1'b1;
      cyc(1);
      timing_tick = 1'b0;
      cyc(1);
   endtask

   task automatic press(input int hold);
      start_btn = 1'b1;
      cyc(hold);
      start_btn = 1'b0;
      cyc(1);
   endtask

   // 59 ticks keep SERVE (a start press in between is ignored); the 60th gives PLAY.
   task automatic serve_play(input logic [3:0] l, input logic [3:0] r);
      for (int i = 0; i < 59; i++) begin
         if (i == 30) press(2);
         do_tick();
      end
      drain("serve_hold");
      push(S_PLAY, l, r, 1'b0, 1'b0, "serve_to_play");
      do_tick();
      drain("serve_to_play");
   endtask

   task automatic point(input logic [10:0] x, input logic [1:0] st, input logic [3:0] l,
                        input logic [3:0] r, input logic w, input string nm);
      x_ball = x;
      push(st, l, r, w, 1'b1, nm);
      do_tick();
      x_ball = 11'd500;
      drain(nm);
      if (st == S_SERV) serve_play(l, r);
   endtask

   initial begin : stim
      rst         = 1'b1;
      timing_tick = 1'b0;
      start_btn   = 1'b0;
      x_ball      = 11'd500;
      push(S_IDLE, 4'd0, 4'd0, 1'b0, 1'b0, "reset_a");
      push(S_IDLE, 4'd0, 4'd0, 1'b0, 1'b0, "reset_b");
      cyc(2);
      rst = 1'b0;
      drain("reset");

      // Reset in the middle of a serve pause
      push(S_SERV, 4'd0, 4'd0, 1'b0, 1'b0, "start_first");
      press(1);
      for (int i = 0; i < 10; i++) do_tick();
      push(S_IDLE, 4'd0, 4'd0, 1'b0, 1'b0, "rst_mid_serve");
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      drain("rst_mid_serve");

      // Held button gives one rise only
      push(S_SERV, 4'd0, 4'd0, 1'b0, 1'b0, "start_held");
      press(10);
      drain("start_held");
      serve_play(4'd0, 4'd0);

      // Right scores; ball stays at the goal through the serve pause
      x_ball = 11'd5;
      push(S_SERV, 4'd0, 4'd1, 1'b0, 1'b1, "goal_x5");
      do_tick();
      drain("goal_x5");
      serve_play(4'd0, 4'd1);
      x_ball = 11'd500;

      // Just inside the field on both sides: no goal
      x_ball = 11'd9;
      do_tick();
      x_ball = 11'd999;
      do_tick();
      x_ball = 11'd1000;
      cyc(5);
      drain("no_goal");

      point(11'd1000, S_SERV, 4'd1, 4'd1, 1'b0, "goal_x1000");
      point(11'd1005, S_SERV, 4'd2, 4'd1, 1'b0, "left_2");
      point(11'd2047, S_SERV, 4'd3, 4'd1, 1'b0, "left_3");
      point(11'd1000, S_SERV, 4'd4, 4'd1, 1'b0, "left_4");
      point(11'd1005, S_OVER, 4'd5, 4'd1, 1'b0, "left_wins");

      // Frozen in GAME_OVER; first start keeps scores, second clears them
      x_ball = 11'd5;
      do_tick();
      x_ball = 11'd500;
      drain("over_frozen");
      push(S_IDLE, 4'd5, 4'd1, 1'b0, 1'b0, "over_to_idle");
      press(3);
      drain("over_to_idle");
      push(S_SERV, 4'd0, 4'd0, 1'b0, 1'b0, "restart");
      press(1);
      drain("restart");
      serve_play(4'd0, 4'd0);

      // Alternate to 4:4
      point(11'd1000, S_SERV, 4'd1, 4'd0, 1'b0, "d_l1");
      point(11'd8,    S_SERV, 4'd1, 4'd1, 1'b0, "d_r1");
      point(11'd1000, S_SERV, 4'd2, 4'd1, 1'b0, "d_l2");
      point(11'd0,    S_SERV, 4'd2, 4'd2, 1'b0, "d_r2");
      point(11'd1000, S_SERV, 4'd3, 4'd2, 1'b0, "d_l3");
      point(11'd8,    S_SERV, 4'd3, 4'd3, 1'b0, "d_r3");
      point(11'd1000, S_SERV, 4'd4, 4'd3, 1'b0, "d_l4");
      point(11'd8,    S_SERV, 4'd4, 4'd4, 1'b0, "d_r4");
`ifdef GAME_WIN_BY_TWO_EN
      point(11'd1000, S_SERV, 4'd5, 4'd4, 1'b0, "deuce_5_4");
      point(11'd1000, S_OVER, 4'd6, 4'd4, 1'b0, "deuce_6_4");
`else
      point(11'd1000, S_OVER, 4'd5, 4'd4, 1'b0, "first_to_5");
`endif

      // Right player wins a fresh game
      push(S_IDLE, 4'(`ifdef GAME_WIN_BY_TWO_EN 6 `else 5 `endif), 4'd4, 1'b0, 1'b0, "idle_keep");
      press(1);
      drain("idle_keep");
      push(S_SERV, 4'd0, 4'd0, 1'b0, 1'b0, "restart2");
      press(1);
      drain("restart2");
      serve_play(4'd0, 4'd0);
      point(11'd3, S_SERV, 4'd0, 4'd1, 1'b0, "r1");
      point(11'd3, S_SERV, 4'd0, 4'd2, 1'b0, "r2");
      point(11'd3, S_SERV, 4'd0, 4'd3, 1'b0, "r3");
      point(11'd3, S_SERV, 4'd0, 4'd4, 1'b0, "r4");
      point(11'd3, S_OVER, 4'd0, 4'd5, 1'b1, "right_wins");

      // Reset coincident with a goal tick: no point, no pulse
      push(S_IDLE, 4'd0, 4'd5, 1'b0, 1'b0, "idle3");
      press(1);
      push(S_SERV, 4'd0, 4'd0, 1'b0, 1'b0, "restart3");
      press(1);
      drain("restart3");
      serve_play(4'd0, 4'd0);
      x_ball      = 11'd5;
      timing_tick = 1'b1;
      rst         = 1'b1;
      push(S_IDLE, 4'd0, 4'd0, 1'b0, 1'b0, "rst_mid_point");
      cyc(1);
      rst         = 1'b0;
      timing_tick = 1'b0;
      x_ball      = 11'd500;
      cyc(4);
      drain("rst_mid_point");

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
